display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across N_DIG common-anode digits.
- Holds a double-buffered display value and selects one nibble per time slot, feeding it to the decoder on `bcd`.
- Drives the active-low anode lines, with a blanking gap at the start of each slot to suppress ghosting.
- Sits between the register/RAM datapath producing values and the board display; the team's shared decoder converts `bcd` to segments.

Parameters:
- N_DIG, 4, number of digits scanned (2..8).
- DIV, 50000, clock cycles per digit slot (must be > BLANK).
- BLANK, 500, cycles at the start of each slot with all anodes off (≥1).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous reset, active-low, sampled on the clk rising edge.
- habil  input  1  scan enable; 0 turns the display off.
- valor  input  4*N_DIG  hex digits; digit 0 is the least-significant nibble [3:0].
- cargar  input  1  one-cycle load strobe; captures `valor`.
- supr_ceros  input  1  blank leading zero digits (most-significant side).
- listo  output  1  1 = no load pending; the last loaded value is on the display.
- bcd  output  4  nibble for the shared decoder.
- an  output  N_DIG  anode enables, active-low, one-hot-low while lit.
- digito  output  $clog2(N_DIG) (min 1)  index of the current slot.

Behaviour:
- One clock domain. Reset is synchronous, active-low (`rst_n`).
- Reset values:
  - an = all 1 (every digit off); bcd = 0; digito = 0; listo = 1.
  - Shadow and active registers = 0; slot counter = 0; FSM = APAGADO.
- Registers:
  - Shadow register `pend`: written by `cargar`.
  - Active register `act`: drives the scan.
  - Only `act` is ever shown.
- Load handshake:
  - `cargar`=1 on an edge: pend <= valor and listo <= 0 on that edge.
  - At the next frame boundary (digit 0 slot start, entering BLANCO with digito=0): act <= pend, listo <= 1.
  - A further `cargar` while listo=0 overwrites pend (last wins); listo stays 0.
  - `cargar` coincident with a frame boundary: the transfer uses the pend value held *before* that edge. The new value is captured into pend and listo goes to 0 (waits one frame).
- FSM states:
  - APAGADO: an = all 1, counter held at 0, digito = 0. On habil=1, go to BLANCO with digito=0; this counts as a frame boundary, so a pending load transfers.
  - BLANCO: an = all 1; counter increments. When counter = BLANK-1, go to ENCENDIDO.
  - ENCENDIDO: an[digito] = 0, all other bits 1. When counter = DIV-1: counter <= 0, digito <= (digito = N_DIG-1) ? 0 : digito+1, go to BLANCO.
  - habil=0 in any state: go to APAGADO on the next edge; an = all 1 from that edge.
- Datapath:
  - bcd = act[4*digito+3 : 4*digito], registered: updates on the same edge digito changes, during the blank window. It is therefore stable before any anode turns on.
  - Latency from the load strobe to the display: at most N_DIG*DIV cycles (one frame), plus one cycle.
- Zero suppression (supr_ceros=1):
  - Digit k stays dark in ENCENDIDO (an[k]=1) if act nibbles k..N_DIG-1 are all 0 and k ≠ 0.
  - Digit 0 is always shown, so a value of 0 displays as "0".
  - Slot timing is unchanged; dark slots still take DIV cycles.
- Counter:
  - Width $clog2(DIV).
  - Never exceeds DIV-1; the counter only wraps at DIV-1.
- Reset mid-slot: all state returns to reset values on that edge, and any pending load is discarded.

Optional Feature:
- Macro: DISPLAY_SCAN_BLINK_EN.
- When defined:
  - Adds input `parpadeo` [N_DIG-1:0] and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles a phase bit every BLINK_FRAMES completed frames.
  - While the phase is 1, digits with parpadeo[k]=1 keep an[k]=1 in ENCENDIDO.
  - The phase and frame counter reset to 0, and are held at 0 in APAGADO.
- When undefined: no port, no counter; behaviour exactly as above.

Test Plan (N_DIG=4, DIV=8, BLANK=2):
- Reset and enable:
  - Stimulus: hold rst_n=0 for 3 cycles, then release with habil=1.
  - Required: an=4'b1111, listo=1, bcd=0 during reset. After release, an stays 1111 for 2 cycles, then an=4'b1110 for 6 cycles, then 2 blank cycles, then an=4'b1101.
- Load at frame boundary:
  - Stimulus: cargar with valor=16'h1A3F mid-slot of digit 2.
  - Required: listo=0 next cycle. Display keeps the old value until the digit-0 slot start, where listo=1. Then bcd sequence F, 3, A, 1 on digito 0..3, each set while an=1111.
- Double load:
  - Stimulus: cargar 16'h1111, then cargar 16'h2222 three cycles later, within one frame.
  - Required: 1111 is never shown; 2222 is shown after the next boundary.
- Zero suppression:
  - Stimulus: act=16'h0050, supr_ceros=1.
  - Required: slots 3 and 2 keep an=1111 for all 8 cycles; digits 1 (bcd=5) and 0 (bcd=0) light. With act=16'h0000, only digit 0 lights.
- Disable and reset mid-operation:
  - Stimulus: habil=0 during ENCENDIDO of digit 1.
  - Required: an=1111 next edge, digito=0. Re-enabling starts with the digit-0 blank.
  - Stimulus: rst_n=0 with a load pending.
  - Required: listo=1 and act=0 after reset.
- Blink (DISPLAY_SCAN_BLINK_EN, BLINK_FRAMES=2):
  - Stimulus: parpadeo=4'b0001.
  - Required: digit 0 is dark in frames 2–3, lit in frames 0–1 and 4–5; other digits always lit.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: scans N_DIG common-anode digits through one shared hex decoder
// Ports: clk; rst_n synchronous active-low reset; habil scan enable (0 = display off);
//   valor/cargar load a new value into the shadow register; supr_ceros blanks leading zeros;
//   listo high when no load is pending; bcd nibble for the shared decoder;
//   an active-low anodes; digito index of the current slot.
// Optional DISPLAY_SCAN_BLINK_EN adds input parpadeo[N_DIG-1:0] and parameter BLINK_FRAMES.
module display_scan_ctrl #(
  parameter int N_DIG = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 500
`ifdef DISPLAY_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      habil,
  input  logic [4*N_DIG-1:0]        valor,
  input  logic                      cargar,
  input  logic                      supr_ceros,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic [N_DIG-1:0]          parpadeo,
`endif
  output logic                      listo,
  output logic [3:0]                bcd,
  output logic [N_DIG-1:0]          an,
  output logic [(N_DIG > 1 ? $clog2(N_DIG) : 1)-1:0] digito
);
  localparam int DW = N_DIG > 1 ? $clog2(N_DIG) : 1;
  localparam int CW = $clog2(DIV);
  typedef enum logic [1:0] {APAGADO, BLANCO, ENCENDIDO} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] dig_n;
  logic [4*N_DIG-1:0] pend, act, act_n;
  logic [N_DIG-1:0] lead0;
  logic wrap, frame, last, z, dark, blink_off;
  assign last = digito == DW'(N_DIG-1);
  // One counter spans the whole slot: blank while below BLANK, lit up to DIV-1.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dig_n = digito;
    wrap = 1'b0;
    if (!habil) begin
      state_n = APAGADO;
      cnt_n = '0;
      dig_n = '0;
    end else begin
      unique case (state)
        APAGADO: begin
          state_n = BLANCO;
          cnt_n = '0;
          dig_n = '0;
        end
        BLANCO: begin
          cnt_n = cnt + 1'b1;
          state_n = cnt == CW'(BLANK-1) ? ENCENDIDO : BLANCO;
        end
        ENCENDIDO: begin
          cnt_n = cnt == CW'(DIV-1) ? '0 : cnt + 1'b1;
          state_n = cnt == CW'(DIV-1) ? BLANCO : ENCENDIDO;
          dig_n = cnt == CW'(DIV-1) ? (last ? '0 : digito + 1'b1) : digito;
          wrap = cnt == CW'(DIV-1) && last;
        end
        default: state_n = APAGADO;
      endcase
    end
  end
  // Entering the digit-0 blank, from a running scan or from off, is a frame boundary.
  assign frame = habil && (state == APAGADO || wrap);
  assign act_n = frame ? pend : act;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= APAGADO;
      cnt <= '0;
      digito <= '0;
      pend <= '0;
      act <= '0;
      listo <= 1'b1;
      bcd <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      digito <= dig_n;
      act <= act_n;
      bcd <= act_n[4*dig_n +: 4];
      pend <= cargar ? valor : pend;
      listo <= cargar ? 1'b0 : (frame ? 1'b1 : listo);
    end
  end
  // lead0[k]: nibbles k..N_DIG-1 of the active value are all zero.
  always_comb begin
    lead0 = '0;
    z = 1'b1;
    for (int k = N_DIG-1; k >= 0; k--) begin
      z = z & (act[4*k +: 4] == 4'd0);
      lead0[k] = z;
    end
  end
`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fcnt;
  logic phase;
  always_ff @(posedge clk) begin
    if (!rst_n || state == APAGADO || !habil) begin
      fcnt <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      fcnt <= fcnt == FW'(BLINK_FRAMES-1) ? '0 : fcnt + 1'b1;
      phase <= fcnt == FW'(BLINK_FRAMES-1) ? ~phase : phase;
    end
  end
  assign blink_off = phase && parpadeo[digito];
`else
  assign blink_off = 1'b0;
`endif
  assign dark = (supr_ceros && digito != '0 && lead0[digito]) || blink_off;
  assign an = state == ENCENDIDO && !dark ? ~(N_DIG'(1) << digito) : '1;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: random and directed stimulus against a slot-position reference model
module tb_display_scan_ctrl;
  localparam int N = 4;
  localparam int DIV = 8;
  localparam int BLANK = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic habil = 1'b0;
  logic [15:0] valor = '0;
  logic cargar = 1'b0;
  logic supr_ceros = 1'b0;
  logic listo;
  logic [3:0] bcd;
  logic [3:0] an;
  logic [1:0] digito;
`ifdef DISPLAY_SCAN_BLINK_EN
  logic [3:0] parpadeo = '0;
`endif
  int n_chk = 0;
  int n_pass = 0;
  bit on = 0;
  int p = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_act = '0;
  bit m_listo = 1;
  display_scan_ctrl #(.N_DIG(N), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .habil(habil), .valor(valor), .cargar(cargar),
    .supr_ceros(supr_ceros),
`ifdef DISPLAY_SCAN_BLINK_EN
    .parpadeo(parpadeo),
`endif
    .listo(listo), .bcd(bcd), .an(an), .digito(digito));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask
  task automatic tick();
    int dig;
    bit bnd, lit;
    logic [15:0] rest;
    @(posedge clk);
    if (!rst_n) begin
      on = 0;
      p = 0;
      m_pend = '0;
      m_act = '0;
      m_listo = 1;
    end else begin
      bnd = 0;
      if (!habil) begin
        on = 0;
        p = 0;
      end else if (!on) begin
        on = 1;
        p = 0;
        bnd = 1;
      end else begin
        p++;
        bnd = (p % (N*DIV)) == 0;
      end
      if (bnd) m_act = m_pend;
      if (cargar) begin
        m_pend = valor;
        m_listo = 0;
      end else if (bnd) m_listo = 1;
    end
    #1;
    dig = on ? (p / DIV) % N : 0;
    rest = m_act >> (4*dig);
    lit = on && (p % DIV) >= BLANK && !(supr_ceros && dig != 0 && rest == 0);
    chk("an", 32'(an), lit ? 32'(~(4'b1 << dig) & 4'hF) : 32'hF);
    chk("bcd", 32'(bcd), 32'(rest[3:0]));
    chk("digito", 32'(digito), 32'(dig));
    chk("listo", 32'(listo), 32'(m_listo));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic load(input logic [15:0] v);
    valor = v;
    cargar = 1'b1;
    tick();
    cargar = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    habil = 1'b1;
    run(3);
    rst_n = 1'b1;
    run(20);
    load(16'h1A3F);
    run(2 * N * DIV);
    load(16'h1111);
    run(2);
    load(16'h2222);
    run(2 * N * DIV);
    supr_ceros = 1'b1;
    load(16'h0050);
    run(2 * N * DIV);
    load(16'h0000);
    run(2 * N * DIV);
    supr_ceros = 1'b0;
    run(N * DIV + DIV + 3);
    habil = 1'b0;
    run(3);
    habil = 1'b1;
    run(N * DIV + 5);
    load(16'hBEEF);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(N * DIV + 4);
    for (int i = 0; i < 4000; i++) begin
      valor = 16'($urandom) >> $urandom_range(0, 16);
      cargar = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 99) == 0) habil = ~habil;
      if ($urandom_range(0, 199) == 0) supr_ceros = ~supr_ceros;
      rst_n = $urandom_range(0, 499) != 0;
      if (!habil && $urandom_range(0, 9) == 0) habil = 1'b1;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
